// File: rtl/me_pkg.sv
// Shared types and defaults for the Montgomery operand feeder.
// Holds the feeder state encoding and default word geometry.
package me_pkg;

  localparam int ME_K = 128;
  localparam int ME_N = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    STREAM,
    WAIT_RES,
    DRAIN
  } me_feed_state_t;

endpackage

// File: rtl/me_word_serializer.sv
// Parallel-load operand register that emits one K-bit word per step.
// Word output is registered and reads zero whenever no step is issued.
module me_word_serializer #(
  parameter int K = 128,
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [K*N-1:0] data_i,
  input  logic           step_i,
  output logic [K-1:0]   word_o
);

  logic [K*N-1:0] sh_q, sh_d;
  logic [K-1:0]   word_q, word_d;

  always_comb begin
    sh_d   = sh_q;
    word_d = '0;
    if (load_i) begin
      sh_d = data_i;
    end else if (step_i) begin
      word_d = sh_q[K-1:0];
      sh_d   = sh_q >> K;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      word_q <= '0;
    end else begin
      sh_q   <= sh_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/me_operand_feeder.sv
// Feeds one X/Y operand pair to the Montgomery core as N+1 words,
// then holds off new operands until the N-beat result has drained.
module me_operand_feeder
  import me_pkg::*;
#(
  parameter int K         = ME_K,
  parameter int N         = ME_N,
  parameter int START_GAP = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K*N-1:0] op_x,
  input  logic [K*N-1:0] op_y,
  input  logic           op_valid,
  output logic           op_ready,
  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic           me_x_valid,
  output logic [K-1:0]   me_y,
  output logic           me_y_valid,
  input  logic           me_valid,
  output logic           busy,
  output logic           err
);

  localparam int BW = $clog2(N + 1);
  localparam int GL = $clog2(START_GAP + 1);
  localparam int GW = (GL > 1) ? GL : 1;
  localparam int DW = $clog2(N + 1);

  me_feed_state_t state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           err_q, err_d;
  logic           ready_q, ready_d;
  logic           start_q, start_d;
  logic           vld_q, vld_d;
  logic           busy_q, busy_d;
  logic           load, step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid && ready_q) state_d = START;
      end
      START: begin
        gap_d   = GW'(START_GAP);
        beat_d  = '0;
        state_d = (START_GAP == 0) ? STREAM : GAP;
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1)) state_d = STREAM;
      end
      STREAM: begin
        if (beat_q == BW'(N)) state_d = WAIT_RES;
        else                  beat_d  = beat_q + 1'b1;
      end
      WAIT_RES: begin
        // The first me_valid cycle already counts as result cycle one
        if (me_valid) begin
          drain_d = DW'(1);
          state_d = (N == 1) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(N - 1)) state_d = IDLE;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (me_valid && (state_q inside {START, GAP, STREAM}))
      err_d = 1'b1;
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    ready_d = (state_d == IDLE);
    start_d = (state_d == START);
    vld_d   = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
    load    = (state_q == IDLE) && op_valid && ready_q;
    step    = vld_d;
  end

  me_word_serializer #(.K(K), .N(N)) u_ser_x (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (op_x),
    .step_i (step),
    .word_o (me_x)
  );

  me_word_serializer #(.K(K), .N(N)) u_ser_y (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (op_y),
    .step_i (step),
    .word_o (me_y)
  );

  assign op_ready   = ready_q;
  assign me_start   = start_q;
  assign me_x_valid = vld_q;
  assign me_y_valid = vld_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_me_operand_feeder.sv
// Directed-random bench for me_operand_feeder with a word-queue model.
// Two instances cover START_GAP=10 and START_GAP=0.
module tb_me_operand_feeder;

  localparam int K    = 128;
  localparam int N    = 32;
  localparam int KN   = K * N;
  localparam int GAPA = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          ov  = 1'b0;
  logic          mv  = 1'b0;
  logic [KN-1:0] opx = '0;
  logic [KN-1:0] opy = '0;

  logic         a_rdy, a_st, a_xv, a_yv, a_busy, a_err;
  logic         z_rdy, z_st, z_xv, z_yv, z_busy, z_err;
  logic [K-1:0] a_x, a_y, z_x, z_y;

  logic         c_rdy, c_st, c_xv, c_yv, c_busy, c_err;
  logic [K-1:0] c_x, c_y;

  int n_asrt = 0;
  int n_fail = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  me_operand_feeder #(.K(K), .N(N), .START_GAP(GAPA)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_x       (opx),
    .op_y       (opy),
    .op_valid   (ov & ~sel),
    .op_ready   (a_rdy),
    .me_start   (a_st),
    .me_x       (a_x),
    .me_x_valid (a_xv),
    .me_y       (a_y),
    .me_y_valid (a_yv),
    .me_valid   (mv & ~sel),
    .busy       (a_busy),
    .err        (a_err)
  );

  me_operand_feeder #(.K(K), .N(N), .START_GAP(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .op_x       (opx),
    .op_y       (opy),
    .op_valid   (ov & sel),
    .op_ready   (z_rdy),
    .me_start   (z_st),
    .me_x       (z_x),
    .me_x_valid (z_xv),
    .me_y       (z_y),
    .me_y_valid (z_yv),
    .me_valid   (mv & sel),
    .busy       (z_busy),
    .err        (z_err)
  );

  assign c_rdy  = sel ? z_rdy  : a_rdy;
  assign c_st   = sel ? z_st   : a_st;
  assign c_xv   = sel ? z_xv   : a_xv;
  assign c_yv   = sel ? z_yv   : a_yv;
  assign c_busy = sel ? z_busy : a_busy;
  assign c_err  = sel ? z_err  : a_err;
  assign c_x    = sel ? z_x    : a_x;
  assign c_y    = sel ? z_y    : a_y;

  task automatic chk(input string tag, input logic [K-1:0] obs,
                     input logic [K-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [KN-1:0] rnd();
    logic [KN-1:0] r;
    for (int i = 0; i < KN / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!c_rdy && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", c_rdy, 1);
  endtask

  task automatic handshake(input logic [KN-1:0] x, input logic [KN-1:0] y);
    wait_ready();
    opx = x;
    opy = y;
    ov  = 1'b1;
    @(negedge clk);
    ov  = 1'b0;
  endtask

  // Starts in the me_start cycle; model is a queue of expected words
  task automatic stream(input logic [KN-1:0] x, input logic [KN-1:0] y,
                        input int err_beat, input int rst_beat);
    logic [K-1:0] qx[$];
    logic [K-1:0] qy[$];
    logic [K-1:0] ex, ey;
    int cyc;
    int gap;
    gap = sel ? 0 : GAPA;
    for (int i = 0; i < N; i++) begin
      qx.push_back(K'(x >> (K * i)));
      qy.push_back(K'(y >> (K * i)));
    end
    qx.push_back('0);
    qy.push_back('0);
    chk("start_hi", c_st, 1);
    chk("busy_hi", c_busy, 1);
    chk("ready_lo", c_rdy, 0);
    @(negedge clk);
    cyc = 1;
    while (!c_xv && cyc < 100) begin
      chk("start_once", c_st, 0);
      @(negedge clk);
      cyc++;
    end
    chk("first_beat_lat", K'(cyc), K'(gap + 1));
    for (int b = 0; b <= N; b++) begin
      ex = qx.pop_front();
      ey = qy.pop_front();
      chk("x_valid", c_xv, 1);
      chk("y_valid", c_yv, 1);
      chk($sformatf("x_beat%0d", b), c_x, ex);
      chk($sformatf("y_beat%0d", b), c_y, ey);
      if (b == err_beat) begin
        mv = 1'b1;
        exp_err = 1'b1;
      end
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_ready", c_rdy, 0);
        chk("rst_start", c_st, 0);
        chk("rst_xv", c_xv, 0);
        chk("rst_yv", c_yv, 0);
        chk("rst_x", c_x, 0);
        chk("rst_y", c_y, 0);
        chk("rst_busy", c_busy, 0);
        chk("rst_err", c_err, 0);
        @(negedge clk);
        rst = 1'b0;
        mv  = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("rel_ready_lo", c_rdy, 0);
        @(negedge clk);
        chk("rel_ready_hi", c_rdy, 1);
        return;
      end
      @(negedge clk);
      mv = 1'b0;
    end
    chk("after_x_valid", c_xv, 0);
    chk("after_y_valid", c_yv, 0);
    chk("after_x", c_x, 0);
    chk("err_flag", c_err, K'(exp_err));
  endtask

  // Core returns N result beats; the feeder reopens the cycle after
  task automatic result();
    for (int i = 0; i < 3; i++) begin
      chk("wait_idle", c_xv, 0);
      chk("wait_ready_lo", c_rdy, 0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      mv = 1'b1;
      chk("drain_ready_lo", c_rdy, 0);
      chk("drain_busy", c_busy, 1);
      @(negedge clk);
    end
    mv = 1'b0;
    chk("ready_reopen", c_rdy, 1);
    chk("busy_lo", c_busy, 0);
    chk("err_keep", c_err, K'(exp_err));
  endtask

  initial begin
    logic [KN-1:0] x1, y1, x2, y2, x3, y3;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst0_ready", c_rdy, 0);
    chk("rst0_start", c_st, 0);
    chk("rst0_xv", c_xv, 0);
    chk("rst0_x", c_x, 0);
    chk("rst0_busy", c_busy, 0);
    chk("rst0_err", c_err, 0);
    rst = 1'b0;
    #1;
    chk("rel0_ready_lo", c_rdy, 0);
    @(negedge clk);
    chk("rel0_ready_hi", c_rdy, 1);

    x1 = rnd();
    x1[51:0] = 52'h2ed070c500db0;
    x1[KN-1 -: 4] = 4'h7;
    y1 = rnd();
    handshake(x1, y1);
    stream(x1, y1, -1, -1);
    result();

    // Second pair held on the bus for the whole first operation
    x2 = rnd(); y2 = rnd();
    x3 = rnd(); y3 = rnd();
    handshake(x2, y2);
    opx = x3;
    opy = y3;
    ov  = 1'b1;
    stream(x2, y2, -1, -1);
    result();
    @(negedge clk);
    ov = 1'b0;
    stream(x3, y3, -1, -1);
    result();

    x1 = rnd(); y1 = rnd();
    handshake(x1, y1);
    stream(x1, y1, 5, -1);
    result();
    chk("err_sticky", c_err, 1);

    x1 = rnd(); y1 = rnd();
    handshake(x1, y1);
    stream(x1, y1, -1, 12);
    chk("err_cleared", c_err, 0);

    for (int i = 0; i < N; i++) x1[K*i +: K] = K'(i);
    y1 = ~x1;
    handshake(x1, y1);
    stream(x1, y1, -1, -1);
    result();

    sel = 1'b1;
    #1;
    x1 = rnd(); y1 = rnd();
    handshake(x1, y1);
    stream(x1, y1, -1, -1);
    result();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/me_operand_feeder.md
# me_operand_feeder

Upstream feeder for the `me_iddmm_top` Montgomery core. The block accepts one full-width operand pair (`op_x`, `op_y`) through a valid/ready handshake and issues a one-cycle `me_start` pulse. After a fixed gap it streams both operands least-significant word first as N+1 K-bit beats on `me_x`/`me_y`. It then blocks new operands until the core has returned its N-beat result.

## Interface
- `K`, 128, word width in bits
- `N`, 32, words per operand (operand width K*N)
- `START_GAP`, 10, idle cycles between the `me_start` cycle and the first beat (0 allowed)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `op_x`  in  K*N  operand X, sampled on handshake
- `op_y`  in  K*N  operand Y, sampled on handshake
- `op_valid`  in  1  operand pair present
- `op_ready`  out  1  feeder can accept a pair
- `me_start`  out  1  one-cycle start pulse to the core
- `me_x`  out  K  current X word
- `me_x_valid`  out  1  X word valid
- `me_y`  out  K  current Y word
- `me_y_valid`  out  1  Y word valid
- `me_valid`  in  1  core result beat valid; first assertion marks result start
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  sticky protocol-error flag

## Operation
- States: IDLE, START, GAP, STREAM, WAIT_RES, DRAIN.
- **IDLE:** `op_ready` is 1. On `op_valid && op_ready`, latch `op_x`/`op_y` into shift registers and go to START.
- **START:** `me_start` is 1 for exactly one cycle. Load the gap counter with `START_GAP`. Go to GAP, or go directly to STREAM if `START_GAP` is 0.
- **GAP:** Decrement the counter each cycle. Go to STREAM after exactly `START_GAP` cycles in GAP.
- **STREAM:** Emit N+1 beats. `me_x_valid` and `me_y_valid` are high on every beat.
  - Beat i (0..N-1) carries word i, i.e. bits [K*i +: K].
  - Beat N carries all zeros on both `me_x` and `me_y` (zero-extension word required by the core).
  - The shift registers shift right by K per beat and fill with zeros.
  - The beat counter runs 0..N. After the beat-N cycle, go to WAIT_RES.
- **WAIT_RES:** Outputs idle. On `me_valid`, go to DRAIN with the drain counter at 1.
- **DRAIN:** Count result cycles. The result occupies N consecutive cycles, including the first `me_valid` cycle. After N total cycles, return to IDLE.
- **Errors:** `me_valid` high in START, GAP, or STREAM sets `err`. The state machine continues unchanged. `err` clears only on reset.
- **Outside handshake:** `op_valid` is ignored while `op_ready` is 0. Operands are not re-sampled.
- **Widths:** the beat counter is `$clog2(N+1)` bits. The gap counter is `max(1, $clog2(START_GAP+1))` bits. The drain counter is `$clog2(N+1)` bits.

## Timing
- All outputs are registered.
- **Reset:**
  - `op_ready`, `me_start`, `me_x`, `me_x_valid`, `me_y`, `me_y_valid`, `busy`, and `err` all go to 0 asynchronously.
  - State goes to IDLE and operand registers clear.
  - `op_ready` rises on the first rising edge after `rst` deasserts.
- **Latency**, with the handshake at edge t:
  - `me_start` is high in cycle t+1.
  - The first beat is in cycle t+2+`START_GAP`.
  - The last (zero) beat is in cycle t+2+`START_GAP`+N.
  - `busy` rises in cycle t+1.
- `op_ready` drops in the cycle after the handshake. It re-asserts in the cycle after the final DRAIN cycle.
- **Back-to-back pairs:** a new pair can be accepted no earlier than the first cycle after DRAIN completes. There is no overlap of operations.
- **Reset mid-operation:** outputs drop to 0 immediately and any partial stream is abandoned. The core must be reset alongside.
- **`me_valid` in the same cycle as the final zero beat:** flag `err`, then enter WAIT_RES. Because that `me_valid` was already consumed, the next `me_valid` is treated as the start of the result.

## Structure
- **Shared package `me_pkg`:**
  - default `K`/`N` localparams
  - the state enum `me_feed_state_t` {IDLE, START, GAP, STREAM, WAIT_RES, DRAIN}
- **Sub-module `me_word_serializer`** (K, N): parallel load of K*N bits, shift-by-K with zero fill, word output. Instantiate it twice, once for X and once for Y. The FSM and counters live in the top.

## Test plan
- **Single pair, K=128, N=32, START_GAP=10:** `op_x` is the 4096-bit value whose word 0 = 128'h...2ed070c500db0 and whose top nibble = 7.
  - `me_start` is high exactly 1 cycle.
  - The first beat is 11 cycles later and `me_x` equals word 0.
  - There are 33 valid beats; beat 32 has `me_x` = `me_y` = 0.
- **Backpressure:** hold `op_valid` = 1 with a second pair during the whole operation.
  - The second pair is accepted only after 32 `me_valid`-started drain cycles.
  - The second `me_start` fires in the cycle after that handshake.
- **START_GAP=0:** the first beat appears in the cycle immediately after `me_start`. Beat count is 33.
- **Protocol error:** pulse `me_valid` during beat 5.
  - `err` becomes 1 and stays 1.
  - The stream still delivers all 33 beats unchanged.
- **Reset mid-stream:** assert `rst` at beat 12.
  - All outputs read 0 the same cycle, and `busy` = 0.
  - After release, `op_ready` = 1 one edge later.
  - A fresh pair streams correctly from word 0.
- **Word ordering:** `op_x` = i in word i for i = 0..31, `op_y` = ~`op_x`.
  - Beat i shows `me_x` = i and `me_y` = ~i.
  - Beat 32 is 0 on both outputs.
